// File: rtl/key_press.sv
// key_press: synchronizes and debounces an active-low pushbutton,
// giving a debounced held level plus one-cycle press/release pulses.
module key_press #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic key_release,
    output logic held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] RELEASED   = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1, r_sync2;
    logic [1:0]    r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_press, r_release, r_held;
    logic          w_s, w_last;

    assign w_s    = ~r_sync2;
    assign w_last = r_cnt == LAST;

    // Entering a debounce state counts the triggering sample as the first one.
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            RELEASED: begin
                w_next = w_s ? DB_PRESS : RELEASED;
                w_cnt  = w_s ? CW'(1) : '0;
            end
            DB_PRESS: begin
                w_next = !w_s ? RELEASED : (w_last ? HELD : DB_PRESS);
                w_cnt  = (!w_s || w_last) ? '0 : r_cnt + CW'(1);
            end
            HELD: begin
                w_next = w_s ? HELD : DB_RELEASE;
                w_cnt  = w_s ? '0 : CW'(1);
            end
            default: begin
                w_next = w_s ? HELD : (w_last ? RELEASED : DB_RELEASE);
                w_cnt  = (w_s || w_last) ? '0 : r_cnt + CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_press   <= r_state == DB_PRESS && w_s && w_last;
            r_release <= r_state == DB_RELEASE && !w_s && w_last;
            r_held    <= w_next == HELD || w_next == DB_RELEASE;
        end
    end

    assign press       = r_press;
    assign key_release = r_release;
    assign held        = r_held;
endmodule

// File: tb/tb_key_press.sv
// tb_key_press: directed checks of key_press debounce timing with DEBOUNCE_CYCLES=4.
module tb_key_press;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic key_n = 1'b1;
    logic press, key_release, held;
    int   n_chk = 0;
    int   n_err = 0;

    key_press #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .press(press),
        .key_release(key_release),
        .held(held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample outputs 1ns after it.
    task automatic cyc(input string tag, input logic ep, input logic er, input logic eh);
        @(posedge clk);
        #1;
        chk({tag, ".press"}, int'(press), int'(ep));
        chk({tag, ".release"}, int'(key_release), int'(er));
        chk({tag, ".held"}, int'(held), int'(eh));
    endtask

    initial begin
        int np, nr, nboth;
        cyc("reset0", 0, 0, 0);
        cyc("reset1", 0, 0, 0);
        reset = 1'b1;
        cyc("idle", 0, 0, 0);

        key_n = 1'b0;
        for (int i = 0; i < 5; i++) cyc("press_wait", 0, 0, 0);
        cyc("press_edge", 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc("press_after", 0, 0, 1);

        key_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc("rel_wait", 0, 0, 1);
        cyc("rel_edge", 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc("rel_after", 0, 0, 0);

        key_n = 1'b0;
        for (int i = 0; i < 3; i++) cyc("bounce_lo1", 0, 0, 0);
        key_n = 1'b1;
        cyc("bounce_hi", 0, 0, 0);
        key_n = 1'b0;
        for (int i = 0; i < 2; i++) cyc("bounce_lo2", 0, 0, 0);
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc("bounce_settle", 0, 0, 0);

        key_n = 1'b0;
        for (int i = 0; i < 5; i++) cyc("press2_wait", 0, 0, 0);
        cyc("press2_edge", 1, 0, 1);
        cyc("press2_after", 0, 0, 1);
        key_n = 1'b1;
        for (int i = 0; i < 2; i++) cyc("rbounce_hi", 0, 0, 1);
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) cyc("rbounce_lo", 0, 0, 1);

        reset = 1'b0;
        cyc("midreset0", 0, 0, 0);
        cyc("midreset1", 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc("rearm_wait", 0, 0, 0);
        cyc("rearm_edge", 1, 0, 1);
        cyc("rearm_after", 0, 0, 1);

        key_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc("rel2_wait", 0, 0, 1);
        cyc("rel2_edge", 0, 1, 0);

        np = 0; nr = 0; nboth = 0;
        key_n = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            np += int'(press);
            nr += int'(key_release);
            nboth += int'(press & key_release);
        end
        chk("long_press_count", np, 1);
        chk("long_release_none", nr, 0);
        chk("long_held", int'(held), 1);
        np = 0; nr = 0;
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            np += int'(press);
            nr += int'(key_release);
            nboth += int'(press & key_release);
        end
        chk("long_rel_press_none", np, 0);
        chk("long_release_count", nr, 1);
        chk("long_released", int'(held), 0);
        chk("never_both", nboth, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
